// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared payload layouts, bubble constants and stall encodings
// for the inter-stage pipeline buffers.
`default_nettype none

package pipe_stage_buf_pkg;

  typedef enum logic {
    STALL_NOSTOP = 1'b0,
    STALL_STOP   = 1'b1
  } stall_e;

  // ID/EX payload: aluop | alusel | reg1 | reg2 | waddr | wreg
  localparam int unsigned c_IDEX_W       = 81;
  localparam int unsigned c_IDEX_WREG_LO  = 0;
  localparam int unsigned c_IDEX_WADDR_LO = 1;
  localparam int unsigned c_IDEX_REG2_LO  = 6;
  localparam int unsigned c_IDEX_REG1_LO  = 38;
  localparam int unsigned c_IDEX_ALUSEL_LO = 70;
  localparam int unsigned c_IDEX_ALUOP_LO = 73;

  // EX/MEM payload: waddr | wdata | wreg | aluop | mem_addr | reg2
  localparam int unsigned c_EXMEM_W          = 110;
  localparam int unsigned c_EXMEM_REG2_LO     = 0;
  localparam int unsigned c_EXMEM_MEM_ADDR_LO = 32;
  localparam int unsigned c_EXMEM_ALUOP_LO    = 64;
  localparam int unsigned c_EXMEM_WREG_LO     = 72;
  localparam int unsigned c_EXMEM_WDATA_LO    = 73;
  localparam int unsigned c_EXMEM_WADDR_LO    = 105;

  // MEM/WB payload: waddr | wdata | wreg
  localparam int unsigned c_MEMWB_W        = 38;
  localparam int unsigned c_MEMWB_WREG_LO  = 0;
  localparam int unsigned c_MEMWB_WDATA_LO = 1;
  localparam int unsigned c_MEMWB_WADDR_LO = 33;

  // Bubble payloads: an all-zero word decodes as "no register write, no memory op"
  localparam logic [c_IDEX_W-1:0]  c_NOP_IDEX  = '0;
  localparam logic [c_EXMEM_W-1:0] c_NOP_EXMEM = '0;
  localparam logic [c_MEMWB_W-1:0] c_NOP_MEMWB = '0;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wreg;
    logic [7:0]  aluop;
    logic [31:0] mem_addr;
    logic [31:0] reg2;
  } exmem_t;

  function automatic logic [c_EXMEM_W-1:0] exmem_pack(input exmem_t f);
    logic [c_EXMEM_W-1:0] w;
    w = '0;
    w[c_EXMEM_REG2_LO     +: 32] = f.reg2;
    w[c_EXMEM_MEM_ADDR_LO +: 32] = f.mem_addr;
    w[c_EXMEM_ALUOP_LO    +: 8]  = f.aluop;
    w[c_EXMEM_WREG_LO]           = f.wreg;
    w[c_EXMEM_WDATA_LO    +: 32] = f.wdata;
    w[c_EXMEM_WADDR_LO    +: 5]  = f.waddr;
    return w;
  endfunction

  function automatic exmem_t exmem_unpack(input logic [c_EXMEM_W-1:0] w);
    exmem_t f;
    f.reg2     = w[c_EXMEM_REG2_LO     +: 32];
    f.mem_addr = w[c_EXMEM_MEM_ADDR_LO +: 32];
    f.aluop    = w[c_EXMEM_ALUOP_LO    +: 8];
    f.wreg     = w[c_EXMEM_WREG_LO];
    f.wdata    = w[c_EXMEM_WDATA_LO    +: 32];
    f.waddr    = w[c_EXMEM_WADDR_LO    +: 5];
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_fifo_ctrl.sv
// pipe_fifo_ctrl: pointer/level bookkeeping for the pipeline buffer; flush beats
// push and pop, ready/valid/stall derive from registered level only.
`default_nettype none

module pipe_fifo_ctrl
  import pipe_stage_buf_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             stall_req,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] c_FULL_LEVEL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_nxt;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full = (r_level == c_FULL_LEVEL);
  assign w_push = in_valid & ~w_full;
  assign w_pop  = (r_level != '0) & out_ready;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      // Write pointer stays put so storage slots are simply reused after a kill
      r_rd_ptr <= r_wr_ptr;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
    end
  end

  assign in_ready  = ~w_full;
  assign out_valid = (r_level != '0);
  assign stall_req = w_full ? STALL_STOP : STALL_NOSTOP;
  assign wr_en     = w_push & ~flush;
  assign wr_ptr    = r_wr_ptr;
  assign rd_ptr    = r_rd_ptr;
  assign level     = r_level;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready buffer between pipeline stages with bubble
// insertion, stall request and flush. PIPE_STAGE_PERF_EN adds stall/bubble counters.
`default_nettype none

module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int                 DATA_W  = c_EXMEM_W,
  parameter int                 DEPTH   = 2,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int                 CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic               w_wr_en;
  logic [c_PTR_W-1:0] w_wr_ptr;
  logic [c_PTR_W-1:0] w_rd_ptr;
  logic               w_in_ready;
  logic               w_out_valid;

  pipe_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (w_in_ready),
    .out_valid (w_out_valid),
    .stall_req (stall_req),
    .wr_en     (w_wr_en),
    .wr_ptr    (w_wr_ptr),
    .rd_ptr    (w_rd_ptr),
    .level     (level)
  );

  // Storage is deliberately not reset; only slots behind a valid level are ever shown
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_ptr] <= in_data;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? r_mem[w_rd_ptr] : NOP_VAL;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  // Saturating counters; flush intentionally leaves them alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (in_valid && !w_in_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!w_out_valid && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: randomized and directed checks of pipe_stage_buf (DEPTH 2 and 4)
// against a queue-based reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_stage_buf;

  localparam int DW = 110;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          flush2 = 1'b0, iv2 = 1'b0, or2 = 1'b0;
  logic [DW-1:0] id2;
  logic          ir2, ov2, sr2;
  logic [DW-1:0] od2;
  logic [1:0]    lv2;
  logic [31:0]   sc2o, bc2o;

  logic          flush4 = 1'b0, iv4 = 1'b0, or4 = 1'b0;
  logic [DW-1:0] id4;
  logic          ir4, ov4, sr4;
  logic [DW-1:0] od4;
  logic [2:0]    lv4;
  logic [31:0]   sc4o, bc4o;

  logic [DW-1:0] q2[$];
  logic [DW-1:0] q4[$];
  int unsigned   sc2 = 0, bc2 = 0, sc4 = 0, bc4 = 0;
  bit            pushed2;
  int            pushes4 = 0;
  int            n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(2), .NOP_VAL('0), .CNT_W(32)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .stall_req(sr2), .level(lv2),
    .stall_cnt(sc2o), .bubble_cnt(bc2o)
  );

  pipe_stage_buf #(.DATA_W(DW), .DEPTH(4), .NOP_VAL('0), .CNT_W(32)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .stall_req(sr4), .level(lv4),
    .stall_cnt(sc4o), .bubble_cnt(bc4o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] cnt_exp(input int unsigned v);
`ifdef PIPE_STAGE_PERF_EN
    return 128'(v);
`else
    return (v == 0) ? 128'd0 : 128'd0;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic check_all();
    chk("d2.out_valid", 128'(ov2), 128'(q2.size() != 0));
    chk("d2.out_data",  128'(od2), (q2.size() != 0) ? 128'(q2[0]) : 128'd0);
    chk("d2.in_ready",  128'(ir2), 128'(q2.size() != 2));
    chk("d2.stall_req", 128'(sr2), 128'(q2.size() == 2));
    chk("d2.level",     128'(lv2), 128'(q2.size()));
    chk("d2.stall_cnt", 128'(sc2o), cnt_exp(sc2));
    chk("d2.bubble_cnt",128'(bc2o), cnt_exp(bc2));
    chk("d4.out_valid", 128'(ov4), 128'(q4.size() != 0));
    chk("d4.out_data",  128'(od4), (q4.size() != 0) ? 128'(q4[0]) : 128'd0);
    chk("d4.in_ready",  128'(ir4), 128'(q4.size() != 4));
    chk("d4.stall_req", 128'(sr4), 128'(q4.size() == 4));
    chk("d4.level",     128'(lv4), 128'(q4.size()));
    chk("d4.stall_cnt", 128'(sc4o), cnt_exp(sc4));
    chk("d4.bubble_cnt",128'(bc4o), cnt_exp(bc4));
  endtask

  // Reference model: advance both queues by one clock using the inputs now applied
  task automatic tick();
    bit pu, po;
    if (q2.size() == 0) bc2++;
    if (iv2 && q2.size() == 2) sc2++;
    pushed2 = 1'b0;
    if (flush2) q2.delete();
    else begin
      pu = iv2 && (q2.size() != 2);
      po = or2 && (q2.size() != 0);
      if (po) void'(q2.pop_front());
      if (pu) q2.push_back(id2);
      pushed2 = pu;
    end
    if (q4.size() == 0) bc4++;
    if (iv4 && q4.size() == 4) sc4++;
    if (flush4) q4.delete();
    else begin
      pu = iv4 && (q4.size() != 4);
      po = or4 && (q4.size() != 0);
      if (po) void'(q4.pop_front());
      if (pu) begin
        q4.push_back(id4);
        pushes4++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q2.delete();
    q4.delete();
    sc2 = 0; bc2 = 0; sc4 = 0; bc4 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] a;
    id2 = 'x;
    id4 = 'x;

    // Reset asserted asynchronously, checked before any clock edge
    #2 rst = 1'b0;
    #1 check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1'b1;

    // Single push with downstream ready
    iv2 = 1'b1; id2 = DW'(128'h1234); or2 = 1'b1;
    tick();
    chk("single.data", 128'(od2), 128'h1234);
    iv2 = 1'b0; id2 = 'x;
    tick();
    chk("single.drain", 128'(ov2), 128'd0);

    // A, B, C into DEPTH=2 with downstream blocked
    or2 = 1'b0; iv2 = 1'b1;
    id2 = DW'(128'hA); tick();
    id2 = DW'(128'hB); tick();
    id2 = DW'(128'hC); tick();
    chk("abc.full_stall", 128'(sr2), 128'd1);
    tick();
    or2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pushed2) break;
    end
    chk("abc.c_accepted", 128'(pushed2), 128'd1);
    iv2 = 1'b0; id2 = 'x;
    for (int i = 0; i < 10 && q2.size() != 0; i++) tick();
    chk("abc.stall_cycles", 128'(sc2o), cnt_exp(3));

    // Flush a full buffer while pushing and popping
    or2 = 1'b0; iv2 = 1'b1;
    id2 = rnd(); tick();
    id2 = rnd(); tick();
    flush2 = 1'b1; or2 = 1'b1; id2 = rnd();
    tick();
    chk("flush.level", 128'(lv2), 128'd0);
    chk("flush.nop", 128'(od2), 128'd0);
    flush2 = 1'b0; iv2 = 1'b0; id2 = 'x;
    tick();

    // Random streaming: DEPTH=4 with toggling ready, DEPTH=2 fully random
    for (int cyc = 0; cyc < 2000 && pushes4 < 100; cyc++) begin
      iv4 = ($urandom_range(3) != 0);
      id4 = iv4 ? rnd() : 'x;
      or4 = ~or4;
      iv2 = $urandom_range(1);
      a = rnd();
      id2 = iv2 ? a : 'x;
      or2 = $urandom_range(1);
      flush2 = ($urandom_range(15) == 0);
      tick();
      chk("d4.level_bound", 128'(lv4 <= 3'd4), 128'd1);
      if (cyc == 60) begin
        // Async reset between edges
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1'b1;
      end
    end
    chk("d4.pushes", 128'(pushes4 >= 100), 128'd1);

    // Drain and idle: bubble counts keep tracking empty cycles
    iv2 = 1'b0; iv4 = 1'b0; id2 = 'x; id4 = 'x;
    or2 = 1'b1; or4 = 1'b1; flush2 = 1'b0; flush4 = 1'b0;
    for (int i = 0; i < 10 && (q2.size() != 0 || q4.size() != 0); i++) tick();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
